// File: rtl/oam_dma.sv
// OAM DMA engine and CPU bus arbiter.
// Copies 160 bytes into OAM; the CPU is limited to HRAM and 0xFF46 while it runs.
module oam_dma #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          START_DELAY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_wren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_reg
);

  typedef enum logic [2:0] {
    IDLE, START, RD_ADDR, RD_DATA, WR
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] src_hi;
  logic [7:0] idx;
  logic [7:0] dly;
  logic [7:0] latch;

  logic reg_sel, reg_wr, hram, busy, stall, last;

  assign reg_sel = cpu_addr == DMA_REG_ADDR;
  assign reg_wr  = reg_sel && cpu_wren;
  assign hram    = cpu_addr >= 16'hFF80
                && cpu_addr <= 16'hFFFE;
  assign busy    = state == RD_ADDR
                || state == RD_DATA
                || state == WR;
  assign stall   = busy && hram;
  assign last    = idx == 8'(DMA_LEN - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      dma_reg <= 8'hFF;
      src_hi  <= 8'hFF;
      idx     <= 8'h00;
      dly     <= 8'h00;
      latch   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (reg_wr) begin
        dma_reg <= cpu_wdata;
        src_hi  <= cpu_wdata;
        idx     <= 8'h00;
        dly     <= 8'(START_DELAY);
      end else begin
        if (state == START && dly != 8'h00)
          dly <= dly - 8'h01;
        if (state == RD_DATA && !stall)
          latch <= mem_rdata;
        if (state == WR && !stall && !last)
          idx <= idx + 8'h01;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (reg_wr) begin
      state_nxt = START;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        START:   if (dly <= 8'h01) state_nxt = RD_ADDR;
        RD_ADDR: if (!stall) state_nxt = RD_DATA;
        // a stalled read lost its data, so reissue it
        RD_DATA: state_nxt = stall ? RD_ADDR : WR;
        WR: begin
          if (!stall) state_nxt = last ? IDLE : RD_ADDR;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wren  = cpu_wren && !reg_wr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    if (busy && !hram) begin
      cpu_rdata = 8'hFF;
      mem_wren  = 1'b0;
      mem_wdata = latch;
      mem_addr  = {src_hi, idx};
      if (state == WR) begin
        mem_addr = {8'hFE, idx};
        mem_wren = 1'b1;
      end
    end
    if (reg_sel) cpu_rdata = dma_reg;
  end

  assign dma_active = state != IDLE;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a synchronous-read memory map model.
// Checks copy contents, cycle counts, arbitration, restart and reset.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_wren;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_wren;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [7:0]  dma_reg;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  s_rdata, s_reg, s_mwren;
  logic        s_active;
  logic [15:0] s_maddr;

  logic [7:0] mem [0:65535];
  logic [7:0] rd_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end
  assign mem_rdata = rd_q;

  oam_dma dut (
    .clock      (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wren   (cpu_wren),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active),
    .dma_reg    (dma_reg)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a,
                     input logic w,
                     input logic [7:0] d);
    cpu_addr  = a;
    cpu_wren  = w;
    cpu_wdata = d;
    @(negedge clk);
    s_rdata  = cpu_rdata;
    s_active = dma_active;
    s_reg    = dma_reg;
    s_maddr  = mem_addr;
    s_mwren  = {7'd0, mem_wren};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int kind,
                                     input int i);
    case (kind)
      0:       return 8'(i) ^ 8'h5A;
      1:       return 8'(i) ^ 8'hA5;
      default: return 8'h11;
    endcase
  endfunction

  task automatic fill(input logic [15:0] base,
                      input int kind);
    for (int i = 0; i < 160; i++)
      cyc(base + 16'(i), 1'b1, pat(kind, i));
    cyc(16'h0000, 1'b0, 8'h00);
  endtask

  function automatic int oam_bad(input int lo,
                                 input int hi,
                                 input int kind);
    int bad = 0;
    for (int i = lo; i <= hi; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat(kind, i))
        bad++;
    return bad;
  endfunction

  // mode 0 plain, 1 hram stalls, 2 restart, 3 reset
  task automatic run_dma(input int mode,
                         input logic [7:0] src,
                         output int act);
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    int          n;
    cyc(16'hFF46, 1'b1, src);
    chk("reg_wr_not_fwd", s_mwren, 0);
    act = -1;
    for (n = 1; n < 800; n++) begin
      a = 16'h0000; w = 1'b0; d = 8'h00;
      reset = 1'b0;
      if (mode == 0 && n == 10) a = 16'hC010;
      if (mode == 0 && n == 12) begin
        a = 16'hC020; w = 1'b1; d = 8'hAA;
      end
      if (mode == 0 && n == 14) a = 16'hFF46;
      if (mode == 1 && n == 11) begin
        a = 16'hFF90; w = 1'b1; d = 8'h77;
      end
      if (mode == 1 && (n == 12 || n == 13))
        a = 16'hFF90;
      if (mode == 2 && n == 152) begin
        a = 16'hFF46; w = 1'b1; d = 8'hD0;
      end
      if (mode == 3 && n == 242) reset = 1'b1;
      cyc(a, w, d);
      if (mode == 0 && n == 1)
        chk("active_rise", s_active, 1);
      if (mode == 0 && n == 10)
        chk("blocked_rd", s_rdata, 8'hFF);
      if (mode == 0 && n == 14)
        chk("reg_rd_busy", s_rdata, src);
      if (mode == 1 && n == 13)
        chk("hram_rdback", s_rdata, 8'h77);
      if (!s_active) begin
        act = n - 1;
        break;
      end
    end
    if (act < 0) chk("dma_timeout", 1, 0);
  endtask

  int act;

  initial begin
    reset = 1'b1;
    cpu_addr = 16'h0000; cpu_wren = 1'b0; cpu_wdata = 8'h00;
    @(posedge clk); #1;
    cyc(16'h0000, 1'b0, 8'h00);
    cyc(16'h0000, 1'b0, 8'h00);
    reset = 1'b0;
    cyc(16'h0000, 1'b0, 8'h00);
    chk("rst_reg", s_reg, 8'hFF);
    chk("rst_active", s_active, 0);

    cyc(16'hFF46, 1'b0, 8'h00);
    chk("idle_reg_rd", s_rdata, 8'hFF);
    cyc(16'h8000, 1'b1, 8'h3C);
    chk("pt_wren", s_mwren, 1);
    chk("pt_addr", s_maddr, 16'h8000);
    cyc(16'h8000, 1'b0, 8'h00);
    chk("pt_mem", mem[16'h8000], 8'h3C);
    cyc(16'h8000, 1'b0, 8'h00);
    chk("pt_rd", s_rdata, 8'h3C);

    fill(16'hC000, 0);
    fill(16'hD000, 1);
    fill(16'hFE00, 2);

    run_dma(0, 8'hC0, act);
    chk("len_plain", act, 481);
    chk("oam_plain", oam_bad(0, 159, 0), 0);
    chk("drop_wr", mem[16'hC020], pat(0, 32));
    cyc(16'hFF46, 1'b0, 8'h00);
    chk("done_active", s_active, 0);
    chk("reg_after", s_rdata, 8'hC0);

    fill(16'hFE00, 2);
    run_dma(1, 8'hC0, act);
    chk("len_stall", act, 484);
    chk("oam_stall", oam_bad(0, 159, 0), 0);
    chk("hram_mem", mem[16'hFF90], 8'h77);

    fill(16'hFE00, 2);
    run_dma(2, 8'hC0, act);
    chk("len_restart", act - 152, 481);
    chk("oam_restart", oam_bad(0, 159, 1), 0);
    chk("reg_restart", s_reg, 8'hD0);

    fill(16'hFE00, 2);
    run_dma(3, 8'hC0, act);
    chk("rst_drop", act, 242);
    chk("rst_dma_reg", s_reg, 8'hFF);
    chk("oam_lo", oam_bad(0, 79, 0), 0);
    chk("oam_hi", oam_bad(80, 159, 2), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
